// File: rtl/rr_grant_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_grant_pkg
//  Description : Shared types, constants and helpers for the round-robin
//                grant FSM (state encoding, default hold limit, one-hot
//                decode).
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package rr_grant_pkg;

    // Largest supported requester count; bounds the one-hot helper width.
    localparam int c_MAX_REQ          = 16;
    localparam int c_MAX_IDW          = 4;
    localparam int c_DEFAULT_MAX_HOLD = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_PARK  = 2'd2
    } state_t;

    // One-hot decode at the maximum width; callers truncate to N bits.
    function automatic logic [c_MAX_REQ-1:0] onehot(input logic [c_MAX_IDW-1:0] idx);
        logic [c_MAX_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Purely combinational rotating-priority picker. Returns the
//                first set request bit scanning from i_ptr upward, wrapping
//                from N-1 back to 0.
//  Ports       : i_req   [N]   request vector
//                i_ptr   [IDW] highest-priority index
//                o_valid       any request set
//                o_idx   [IDW] winning index (0 when none)
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic           o_valid,
    output logic [IDW-1:0] o_idx
);

    int w_pos;

    // Scan offsets from farthest to nearest so the nearest hit to i_ptr
    // overwrites any earlier one and ends up as the winner.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_pos   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            w_pos = (int'(i_ptr) + i) % N;
            if (i_req[w_pos]) begin
                o_valid = 1'b1;
                o_idx   = IDW'(w_pos);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_grant_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : rr_grant_fsm
//  Description : Round-robin arbiter FSM granting one shared resource to one
//                of N requesters. A grant is held until the owner releases,
//                drops its request, or the hold timer expires; a one-cycle
//                PARK turnaround separates consecutive grants.
//  Ports       : clk                rising-edge clock
//                reset              synchronous active-high reset
//                req        [N]     level requests
//                release_in [N]     release strobes (owner bit only honoured;
//                                   "release" is a reserved word)
//                grant      [N]     registered one-hot grant
//                grant_id   [IDW]   owner index, 0 when idle
//                busy               grant held
//                timeout            one-cycle pulse on hold-timer revoke
//  Revision    : 1.0  initial release
// ============================================================================
module rr_grant_fsm
    import rr_grant_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = c_DEFAULT_MAX_HOLD,
    localparam int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   release_in,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           busy,
    output logic           timeout
);

    localparam int HCW = $clog2(MAX_HOLD);
    localparam logic [HCW-1:0] c_HOLD_LAST = HCW'(MAX_HOLD - 1);

    state_t         r_state_q,    w_state_d;
    logic [IDW-1:0] r_ptr_q,      w_ptr_d;
    logic [HCW-1:0] r_hold_cnt_q, w_hold_cnt_d;
    logic [N-1:0]   r_grant_q,    w_grant_d;
    logic [IDW-1:0] r_grant_id_q, w_grant_id_d;
    logic           r_busy_q,     w_busy_d;
    logic           r_timeout_q,  w_timeout_d;

    logic           w_pick_valid;
    logic [IDW-1:0] w_pick_idx;
    logic           w_own_rel;
    logic           w_own_drop;
    logic           w_hold_hit;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr_q),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    assign w_own_rel  = release_in[r_grant_id_q];
    assign w_own_drop = ~req[r_grant_id_q];
    assign w_hold_hit = (r_hold_cnt_q == c_HOLD_LAST);

    always_comb begin
        w_state_d    = r_state_q;
        w_ptr_d      = r_ptr_q;
        w_hold_cnt_d = r_hold_cnt_q;
        w_grant_d    = r_grant_q;
        w_grant_id_d = r_grant_id_q;
        w_busy_d     = r_busy_q;
        w_timeout_d  = 1'b0;

        case (r_state_q)
            ST_GRANT: begin
                if (w_own_rel || w_own_drop || w_hold_hit) begin
                    w_state_d    = ST_PARK;
                    w_grant_d    = '0;
                    w_grant_id_d = '0;
                    w_busy_d     = 1'b0;
                    w_hold_cnt_d = '0;
                    w_ptr_d      = (int'(r_grant_id_q) == N - 1) ? '0 : r_grant_id_q + 1'b1;
                    // A voluntary exit on the same edge as the limit wins.
                    w_timeout_d  = w_hold_hit && !w_own_rel && !w_own_drop;
                end else begin
                    w_hold_cnt_d = r_hold_cnt_q + 1'b1;
                end
            end
            // IDLE and PARK arbitrate identically; PARK only exists to force
            // the one-cycle zero-grant gap.
            ST_IDLE, ST_PARK: begin
                w_hold_cnt_d = '0;
                if (w_pick_valid) begin
                    w_state_d    = ST_GRANT;
                    w_grant_d    = N'(onehot(c_MAX_IDW'(w_pick_idx)));
                    w_grant_id_d = w_pick_idx;
                    w_busy_d     = 1'b1;
                end else begin
                    w_state_d    = ST_IDLE;
                    w_grant_d    = '0;
                    w_grant_id_d = '0;
                    w_busy_d     = 1'b0;
                end
            end
            default: begin
                w_state_d    = ST_IDLE;
                w_grant_d    = '0;
                w_grant_id_d = '0;
                w_busy_d     = 1'b0;
                w_hold_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q    <= ST_IDLE;
            r_ptr_q      <= '0;
            r_hold_cnt_q <= '0;
            r_grant_q    <= '0;
            r_grant_id_q <= '0;
            r_busy_q     <= 1'b0;
            r_timeout_q  <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_ptr_q      <= w_ptr_d;
            r_hold_cnt_q <= w_hold_cnt_d;
            r_grant_q    <= w_grant_d;
            r_grant_id_q <= w_grant_id_d;
            r_busy_q     <= w_busy_d;
            r_timeout_q  <= w_timeout_d;
        end
    end

    assign grant    = r_grant_q;
    assign grant_id = r_grant_id_q;
    assign busy     = r_busy_q;
    assign timeout  = r_timeout_q;

endmodule
`default_nettype wire
